shiftreg_tx: RTL and testbench

Parallel-in, serial-out transmitter that is the sending end of the one-bit-per-strobe link consumed by `shiftreg`. A 51-bit word is accepted through a valid/ready load handshake and emitted one bit per cycle on `x_n`, qualified by `ready_out`. `ready_out` drives the receiver's `ready_in`. It sits between the sample/control source and `shiftreg`, so the receiver's register reproduces the loaded word.

---
 rtl/shiftreg_pkg.sv | 5 +
 rtl/bit_counter.sv | 18 +
 rtl/shiftreg_tx.sv | 83 ++++++++
 tb/tb_shiftreg_tx.sv | 121 ++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: state type and word width shared by shiftreg_tx and shiftreg
package shiftreg_pkg;
    localparam int SHIFT_WIDTH = 51;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} tx_state_t;
endpackage

// File: rtl/bit_counter.sv
// bit_counter: saturating up-counter with clear, enable and terminal-count flag
module bit_counter #(
    parameter int W   = 6,
    parameter int MAX = 50
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = cnt == W'(MAX);
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/shiftreg_tx.sv
// shiftreg_tx: parallel-in serial-out sender for shiftreg; SHIFTREG_TX_PARITY_EN appends an even-parity bit
module shiftreg_tx
    import shiftreg_pkg::*;
#(
    parameter int WIDTH     = SHIFT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             tx_stall,
    output logic             x_n,
    output logic             ready_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    tx_state_t state, next;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0] cnt;
    logic tc, up, load, shift;
    assign load  = state == IDLE && load_valid && up;
    assign shift = state == SHIFT && !tx_stall;
    assign busy  = state != IDLE;
    bit_counter #(.W(CW), .MAX(WIDTH - 1)) u_cnt (
        .clk(clk), .nreset(nreset), .clr(load), .en(shift), .cnt(cnt), .tc(tc)
    );
    // up keeps load_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            state <= IDLE;
            up    <= 1'b0;
            sr    <= '0;
        end else begin
            state <= next;
            up    <= 1'b1;
            if (load) sr <= load_data;
            else if (shift) sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        end
`ifdef SHIFTREG_TX_PARITY_EN
    logic par;
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) par <= 1'b0;
        else if (load) par <= ^load_data;
`endif
    always_comb begin
        next       = state;
        load_ready = 1'b0;
        ready_out  = 1'b0;
        x_n        = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = up;
                if (load) next = SHIFT;
            end
            SHIFT: begin
                x_n       = MSB_FIRST ? sr[WIDTH-1] : sr[0];
                ready_out = !tx_stall;
`ifdef SHIFTREG_TX_PARITY_EN
                if (shift && tc) next = PARITY;
`else
                if (shift && tc) next = DONE;
`endif
            end
`ifdef SHIFTREG_TX_PARITY_EN
            PARITY: begin
                x_n       = par;
                ready_out = !tx_stall;
                if (!tx_stall) next = DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: ;
        endcase
    end
    assert property (@(posedge clk) disable iff (!nreset) state == SHIFT |-> cnt <= CW'(WIDTH - 1));
endmodule

// File: tb/tb_shiftreg_tx.sv
// tb_shiftreg_tx: directed checks of shiftreg_tx with a receiver loopback model
module tb_shiftreg_tx;
    localparam int W = 51;
`ifdef SHIFTREG_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    logic clk = 1'b0, nreset = 1'b0, load_valid = 1'b0, tx_stall = 1'b0;
    logic [W-1:0] load_data = '0;
    logic load_ready, x_n, ready_out, busy, done;
    int checks = 0, errors = 0;

    shiftreg_tx dut (
        .clk(clk), .nreset(nreset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .tx_stall(tx_stall), .x_n(x_n), .ready_out(ready_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at edge+1 in IDLE; returns at edge+1 one cycle after done
    task automatic send(input logic [W-1:0] w, input bit exp_par, input int stall_at,
                        input int stall_len, input int poke_at);
        logic [63:0] rx = '0;
        int strobes = 0, cyc = 0, stalled = 0;
        bit seen = 0, poked = 0;
        check("idle_load_ready", load_ready, 1);
        load_data  = w;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_data = '1;
        while (!seen && cyc < 300) begin
            load_valid = 1'b0;
            tx_stall   = strobes == stall_at && stalled < stall_len;
            if (strobes == poke_at && !poked) begin
                load_valid = 1'b1;
                load_data  = 51'h7;
                poked      = 1;
            end
            #1;
            if (load_valid) check("busy_load_ready", load_ready, 0);
            if (cyc == 0) begin
                check("first_ready_out", ready_out, 1'(stall_at != 0));
                check("busy", busy, 1);
            end
            if (done) seen = 1;
            else if (ready_out) begin
                rx = {rx[62:0], x_n};
                strobes++;
            end else begin
                check("stall_x_n", x_n, w[W-1-strobes]);
                stalled++;
            end
            if (!seen) cyc++;
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        tx_stall   = 1'b0;
        check("done_seen", seen, 1);
        check("done_one_cycle", done, 0);
        check("load_ready_after", load_ready, 1);
        check("strobes", strobes, NB);
        check("cycles", cyc, NB + stall_len);
`ifdef SHIFTREG_TX_PARITY_EN
        check("rx_word", rx[W:1], 64'(w));
        check("parity_bit", rx[0], exp_par);
`else
        check("rx_word", rx, 64'(w));
        check("unused_par", exp_par, exp_par);
`endif
    endtask

    initial begin
        #2;
        check("rst_load_ready", load_ready, 0);
        check("rst_x_n", x_n, 0);
        check("rst_ready_out", ready_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        nreset = 1'b1;
        check("pre_edge_load_ready", load_ready, 0);
        @(posedge clk); #1;
        send(51'h1, 1'b1, -1, 0, -1);
        send(51'h5_5555_5555_5555, 1'b0, -1, 0, -1);
        send(51'h5_5555_5555_5555, 1'b0, 10, 3, -1);
        send(51'h4_0000_0000_0001, 1'b0, -1, 0, 25);
        // abort an all-ones word while bit 20 is on the wire
        load_data  = 51'h7_FFFF_FFFF_FFFF;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("abort_pre_x_n", x_n, 1);
        nreset = 1'b0;
        #1;
        check("abort_x_n", x_n, 0);
        check("abort_ready_out", ready_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_load_ready", load_ready, 0);
        @(posedge clk); #1;
        check("abort_no_done", done, 0);
        nreset = 1'b1;
        @(posedge clk); #1;
        send(51'h3, 1'b0, -1, 0, -1);
        send(51'h7, 1'b1, -1, 0, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
